// File: rtl/ifetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_if : imem handshake, decoded-instruction and next-PC bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ifetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_out;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            instr_done;
  logic            PCSrc;
  logic [XLEN-1:0] PCTarget;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
           op, funct3, funct7, rs1, rs2, rd, fetch_err,
    input  imem_ack, imem_rdata, instr_done, PCSrc, PCTarget
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
           op, funct3, funct7, rs1, rs2, rd, fetch_err,
    output imem_ack, imem_rdata, instr_done, PCSrc, PCTarget
  );
endinterface
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch : PC owner, imem req/ack fetch, instruction register, decode  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ifetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  ifetch_if.master  bus_io
);

  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        if (bus_io.imem_ack) begin
          instr_d = bus_io.imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus_io.instr_done) begin
          valid_d = 1'b0;
          // A misaligned taken target faults without disturbing the PC
          if (bus_io.PCSrc && (bus_io.PCTarget[1:0] != 2'b00)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            pc_d    = bus_io.PCSrc ? bus_io.PCTarget : pc_q + XLEN'(4);
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = S_ERR;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  assign bus_io.imem_req    = (state_q == S_REQ);
  assign bus_io.imem_addr   = pc_q;
  assign bus_io.pc_out      = pc_q;
  assign bus_io.instr       = instr_q;
  assign bus_io.instr_valid = valid_q;
  assign bus_io.fetch_err   = err_q;
  assign bus_io.op          = instr_q[6:0];
  assign bus_io.funct3      = instr_q[14:12];
  assign bus_io.funct7      = instr_q[30];
  assign bus_io.rs1         = instr_q[19:15];
  assign bus_io.rs2         = instr_q[24:20];
  assign bus_io.rd          = instr_q[11:7];

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch : directed stimulus with scoreboard/monitor for ifetch     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ifetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_if #(.XLEN(32)) bus ();

  ifetch #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new instruction presented is checked against the scoreboard
  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got %h, expected none", bus.instr);
      end else begin
        m_e = sb.pop_front();
        check("mon_pc", bus.pc_out, m_e.pc);
        check("mon_instr", bus.instr, m_e.instr);
        check("mon_op", 32'(bus.op), 32'(m_e.op));
        check("mon_funct3", 32'(bus.funct3), 32'(m_e.f3));
        check("mon_funct7", 32'(bus.funct7), 32'(m_e.f7));
        check("mon_rs1", 32'(bus.rs1), 32'(m_e.rs1));
        check("mon_rs2", 32'(bus.rs2), 32'(m_e.rs2));
        check("mon_rd", 32'(bus.rd), 32'(m_e.rd));
      end
    end
    prev_valid = bus.instr_valid;
  end

  task automatic wait_req();
    int i = 0;
    while (bus.imem_req !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (bus.imem_req !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_req_timeout: got req=%b, expected 1", bus.imem_req);
    end
  endtask

  task automatic fetch(input int delay, input logic [31:0] word, input logic [31:0] epc,
                       input logic [6:0] eop, input logic [2:0] ef3, input logic ef7,
                       input logic [4:0] ers1, input logic [4:0] ers2, input logic [4:0] erd);
    exp_t e;
    wait_req();
    check("req_addr", bus.imem_addr, epc);
    for (int i = 0; i < delay; i++) begin
      check("wait_req", 32'(bus.imem_req), 32'd1);
      check("wait_addr", bus.imem_addr, epc);
      check("wait_valid", 32'(bus.instr_valid), 32'd0);
      check("wait_err", 32'(bus.fetch_err), 32'd0);
      @(negedge clk);
    end
    e = '{pc: epc, instr: word, op: eop, f3: ef3, f7: ef7, rs1: ers1, rs2: ers2, rd: erd};
    sb.push_back(e);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic done(input logic src, input logic [31:0] tgt, input logic [31:0] eaddr);
    bus.instr_done = 1'b1;
    bus.PCSrc      = src;
    bus.PCTarget   = tgt;
    @(negedge clk);
    bus.instr_done = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.PCTarget   = $urandom;
    check("done_valid", 32'(bus.instr_valid), 32'd0);
    check("done_req", 32'(bus.imem_req), 32'd1);
    check("done_addr", bus.imem_addr, eaddr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_done = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.PCTarget   = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd1);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0000_0013);
    check("rst_err", 32'(bus.fetch_err), 32'd0);
    rst = 1'b0;

    // Sequential fetch, fall-through, taken branch, address wrap
    fetch(0, 32'h0000_0013, 32'h0, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    done(1'b0, 32'h0, 32'h4);
    fetch(0, 32'h0000_2083, 32'h4, 7'h03, 3'd2, 1'b0, 5'd0, 5'd0, 5'd1);
    done(1'b0, 32'h0, 32'h8);
    fetch(0, 32'h0020_8463, 32'h8, 7'h63, 3'd0, 1'b0, 5'd1, 5'd2, 5'd8);
    done(1'b1, 32'h40, 32'h40);
    fetch(0, 32'h4020_81B3, 32'h40, 7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3);
    done(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(0, 32'h0000_0013, 32'hFFFF_FFFC, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    done(1'b0, 32'h0, 32'h0);

    // Spurious instr_done in REQ must not redirect
    bus.instr_done = 1'b1;
    bus.PCSrc      = 1'b1;
    bus.PCTarget   = 32'h80;
    @(negedge clk);
    bus.instr_done = 1'b0;
    bus.PCSrc      = 1'b0;
    check("spur_done_addr", bus.imem_addr, 32'h0);
    check("spur_done_req", 32'(bus.imem_req), 32'd1);
    fetch(3, 32'h0000_2083, 32'h0, 7'h03, 3'd2, 1'b0, 5'd0, 5'd0, 5'd1);

    // Spurious ack in HOLD must not overwrite the instruction
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("spur_ack_instr", bus.instr, 32'h0000_2083);
    check("spur_ack_valid", 32'(bus.instr_valid), 32'd1);
    check("spur_ack_req", 32'(bus.imem_req), 32'd0);

    // Ack timeout: fault on the 16th waiting cycle
    done(1'b0, 32'h0, 32'h4);
    for (int i = 1; i <= 16; i++) begin
      check("to_wait_req", 32'(bus.imem_req), 32'd1);
      check("to_wait_err", 32'(bus.fetch_err), 32'd0);
      @(negedge clk);
    end
    check("to_err", 32'(bus.fetch_err), 32'd1);
    check("to_req", 32'(bus.imem_req), 32'd0);
    check("to_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack   = 1'b1;
      bus.instr_done = 1'b1;
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      bus.instr_done = 1'b0;
      check("to_sticky_err", 32'(bus.fetch_err), 32'd1);
      check("to_sticky_req", 32'(bus.imem_req), 32'd0);
      check("to_sticky_valid", 32'(bus.instr_valid), 32'd0);
    end
    do_reset();
    check("to_rst_err", 32'(bus.fetch_err), 32'd0);
    check("to_rst_req", 32'(bus.imem_req), 32'd1);
    check("to_rst_addr", bus.imem_addr, 32'h0);

    // Misaligned taken target
    fetch(0, 32'h0000_0013, 32'h0, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    bus.instr_done = 1'b1;
    bus.PCSrc      = 1'b1;
    bus.PCTarget   = 32'h42;
    @(negedge clk);
    bus.instr_done = 1'b0;
    bus.PCSrc      = 1'b0;
    check("mis_err", 32'(bus.fetch_err), 32'd1);
    check("mis_req", 32'(bus.imem_req), 32'd0);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);
    check("mis_pc", bus.pc_out, 32'h0);
    repeat (3) begin
      bus.imem_ack   = 1'b1;
      bus.instr_done = 1'b1;
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      bus.instr_done = 1'b0;
      check("mis_sticky_err", 32'(bus.fetch_err), 32'd1);
      check("mis_sticky_addr", bus.imem_addr, 32'h0);
    end
    do_reset();
    check("mis_rst_err", 32'(bus.fetch_err), 32'd0);

    // Reset mid-HOLD at PC=0x40
    fetch(0, 32'h0000_0013, 32'h0, 7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    done(1'b1, 32'h40, 32'h40);
    fetch(0, 32'h0000_2083, 32'h40, 7'h03, 3'd2, 1'b0, 5'd0, 5'd0, 5'd1);
    check("hold_pc", bus.pc_out, 32'h40);
    do_reset();
    check("hrst_pc", bus.pc_out, 32'h0);
    check("hrst_valid", 32'(bus.instr_valid), 32'd0);
    check("hrst_instr", bus.instr, 32'h0000_0013);
    check("hrst_req", 32'(bus.imem_req), 32'd1);

    // Reset with an ack in flight discards the ack
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    check("rack_valid", 32'(bus.instr_valid), 32'd0);
    check("rack_instr", bus.instr, 32'h0000_0013);
    check("rack_req", 32'(bus.imem_req), 32'd1);
    fetch(0, 32'h4020_81B3, 32'h0, 7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch.md
Name: ifetch

Overview:
Instruction fetch stage that sits directly upstream of ctrl. It owns the PC and fetches each instruction from instruction memory over a req/ack handshake. It holds the instruction in an instruction register and presents the decoded fields (op, funct3, funct7, register indices) to ctrl and the register file until the core signals completion. Next-PC selection consumes ctrl's PCSrc and the datapath's branch/jump target.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
TIMEOUT, 16, max cycles waiting for imem_ack before fault (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request, level, held until ack
imem_addr  out  XLEN  fetch address (current PC)
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
instr_valid  out  1  instruction register holds a live instruction
instr  out  32  instruction register
pc_out  out  XLEN  PC of held instruction
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  1  instr[30]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
rd  out  5  instr[11:7]
instr_done  in  1  core finished held instruction; PCSrc/PCTarget valid this cycle
PCSrc  in  1  from ctrl: take PCTarget
PCTarget  in  XLEN  branch/jump target
fetch_err  out  1  sticky fault flag

Behaviour:
- States: REQ, HOLD, ERR.
- Reset: state=REQ, PC=RESET_PC, instr=32'h0000_0013 (addi x0,x0,0), instr_valid=0, fetch_err=0, timeout counter=0.
- imem_req=1 only in REQ; imem_addr=PC always; pc_out=PC.
- REQ: hold imem_req and imem_addr stable. Counter increments each cycle without ack.
  - On imem_ack (including the first REQ cycle): instr<=imem_rdata, instr_valid<=1, counter<=0, go to HOLD. Valid rises the cycle after ack.
  - If counter reaches TIMEOUT-1 with no ack: go to ERR, fetch_err<=1. fetch_err is set on the TIMEOUT-th waiting cycle's edge.
- HOLD: instr and fields stay stable; instr_valid=1.
  - On instr_done: PC<=PCSrc ? PCTarget : PC+4 (mod 2^XLEN, wraps), instr_valid<=0, go to REQ.
  - If PCSrc=1 and PCTarget[1:0]!=0: go to ERR, fetch_err<=1, PC unchanged, instr_valid<=0.
- Latency: instr_done at edge n -> imem_req at cycle n+1 -> with same-cycle ack, instr_valid at cycle n+2. Throughput is one instruction per 2 cycles minimum.
- ERR: imem_req=0, instr_valid=0, fetch_err=1. Only rst exits ERR.
- imem_ack outside REQ is ignored. instr_done outside HOLD is ignored. PCSrc/PCTarget are sampled only with instr_done in HOLD.
- Fields are pure slices of instr, so they are stable while instr_valid=1.
- rst asserted in any state, including mid-REQ with ack pending, returns to the reset values at the next edge. Any in-flight ack is discarded.

Test Plan:
1. Reset, RESET_PC=0; release; ack same cycle with 0x00000013 -> imem_req=1/addr=0 first cycle; next cycle instr_valid=1, op=0010011, funct3=000, rd=0.
2. In HOLD pulse instr_done with PCSrc=0 -> instr_valid=0 next cycle, imem_req=1, imem_addr=0x4. Ack 0x00002083 (lw x1,0(x0)) -> op=0000011, funct3=010, rd=1.
3. Held beq 0x00208463, instr_done with PCSrc=1, PCTarget=0x40 -> imem_addr=0x40. Also PC=0xFFFFFFFC with PCSrc=0 -> imem_addr wraps to 0x0.
4. Ack delayed 3 cycles -> imem_req=1 and imem_addr constant for 4 cycles, instr_valid=0 until cycle after ack, fetch_err=0. Spurious ack/instr_done in wrong state -> no state change.
5. No ack for TIMEOUT=16 cycles -> fetch_err=1, imem_req=0 afterwards. Misaligned PCTarget=0x42 with PCSrc=1 -> fetch_err=1, PC unchanged. Both faults persist until rst.
6. rst asserted mid-HOLD (instr_valid=1, PC=0x40) -> next cycle PC=0, instr_valid=0, instr=0x00000013, imem_req=1.
